// File: rtl/vectoring_postproc_if.sv
// Result stream from the vectoring post-processor to the next ray stage:
// valid/ready handshake carrying gain-corrected magnitude, clamped angle and tag.
interface vectoring_postproc_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ID_WIDTH   = 8
);
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_mag;
  logic signed [DATA_WIDTH-1:0] out_ang;
  logic [ID_WIDTH-1:0]          out_id;

  modport master (
    output out_valid, out_mag, out_ang, out_id,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_mag, out_ang, out_id,
    output out_ready
  );
endinterface

// File: rtl/vectoring_postproc.sv
// Vectoring CORDIC post-processor: removes the CORDIC gain from the magnitude, clamps
// the angle to +/-pi, and buffers the results in a small FIFO behind a valid/ready port.
module vectoring_postproc #(
  parameter int DATA_WIDTH = 12,
  parameter int ID_WIDTH   = 8,
  parameter int INV_GAIN   = 2487,
  parameter int PI_Q48     = 804,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic signed [DATA_WIDTH-1:0]        in_mag,
  input  logic signed [DATA_WIDTH-1:0]        in_ang,
  input  logic [ID_WIDTH-1:0]                 in_id,
  vectoring_postproc_if.master                out_if,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
  output logic                                overflow,
  input  logic                                clear_overflow
);
  localparam int FRAC   = 12;
  localparam int PROD_W = DATA_WIDTH + FRAC;
  localparam int MAG_W  = PROD_W - FRAC + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;

  localparam logic [FRAC-1:0]              GAIN_Q012 = INV_GAIN[FRAC-1:0];
  localparam logic signed [PROD_W:0]       ROUND_ADD = (PROD_W+1)'(1 << (FRAC - 1));
  localparam logic signed [MAG_W-1:0]      MAG_MAX   = MAG_W'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [DATA_WIDTH-1:0] ANG_MAX   = PI_Q48[DATA_WIDTH-1:0];
  localparam logic signed [DATA_WIDTH-1:0] ANG_MIN   = -ANG_MAX;

  // Round half up, then clip to [0, max]: a gain-corrected magnitude is never negative.
  function automatic logic signed [DATA_WIDTH-1:0] round_sat_mag(
    input logic signed [PROD_W-1:0] p
  );
    logic signed [PROD_W:0]  s;
    logic signed [MAG_W-1:0] m;
    s = $signed({p[PROD_W-1], p}) + ROUND_ADD;
    m = s[PROD_W:FRAC];
    if (m < 0)             return '0;
    else if (m > MAG_MAX)  return MAG_MAX[DATA_WIDTH-1:0];
    else                   return m[DATA_WIDTH-1:0];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] clamp_ang(
    input logic signed [DATA_WIDTH-1:0] a
  );
    if (a < ANG_MIN)       return ANG_MIN;
    else if (a > ANG_MAX)  return ANG_MAX;
    else                   return a;
  endfunction

  logic signed [PROD_W-1:0] w_mag_x;
  logic signed [PROD_W-1:0] w_gain_x;
  logic signed [PROD_W-1:0] w_prod_p0;
  logic                     w_vld_p0;

  assign w_mag_x   = {{FRAC{in_mag[DATA_WIDTH-1]}}, in_mag};
  assign w_gain_x  = $signed({{DATA_WIDTH{1'b0}}, GAIN_Q012});
  assign w_prod_p0 = w_mag_x * w_gain_x;
  assign w_vld_p0  = (in_id != '0);

  // ---- stage 1: raw product, tag and angle ----
  logic                         r_vld_p1;
  logic [ID_WIDTH-1:0]          r_id_p1;
  logic signed [PROD_W-1:0]     r_prod_p1;
  logic signed [DATA_WIDTH-1:0] r_ang_p1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_vld_p1 <= 1'b0;
      r_id_p1  <= '0;
    end else begin
      r_vld_p1 <= w_vld_p0;
      r_id_p1  <= in_id;
    end
  end

  always_ff @(posedge clock) begin
    r_prod_p1 <= w_prod_p0;
    r_ang_p1  <= in_ang;
  end

  // ---- stage 2: rounded/saturated magnitude, clamped angle ----
  logic                         r_vld_p2;
  logic [ID_WIDTH-1:0]          r_id_p2;
  logic signed [DATA_WIDTH-1:0] r_mag_p2;
  logic signed [DATA_WIDTH-1:0] r_ang_p2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_vld_p2 <= 1'b0;
      r_id_p2  <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      r_id_p2  <= r_id_p1;
    end
  end

  always_ff @(posedge clock) begin
    r_mag_p2 <= round_sat_mag(r_prod_p1);
    r_ang_p2 <= clamp_ang(r_ang_p1);
  end

  // ---- stage 3: output FIFO ----
  logic signed [DATA_WIDTH-1:0] r_mem_mag [FIFO_DEPTH];
  logic signed [DATA_WIDTH-1:0] r_mem_ang [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]          r_mem_id  [FIFO_DEPTH];
  logic [PTR_W-1:0]             r_wr_ptr;
  logic [PTR_W-1:0]             r_rd_ptr;
  logic [LVL_W-1:0]             r_count;
  logic                         r_overflow;

  logic w_valid, w_full, w_pop, w_wr, w_drop;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == LVL_W'(FIFO_DEPTH));
  assign w_pop   = w_valid & out_if.out_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign w_wr    = r_vld_p2 & (~w_full | w_pop);
  assign w_drop  = r_vld_p2 & w_full & ~w_pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_mag[i] <= '0;
        r_mem_ang[i] <= '0;
        r_mem_id[i]  <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem_mag[r_wr_ptr] <= r_mag_p2;
        r_mem_ang[r_wr_ptr] <= r_ang_p2;
        r_mem_id[r_wr_ptr]  <= r_id_p2;
        r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_wr && !w_pop)
        r_count <= r_count + LVL_W'(1);
      else if (!w_wr && w_pop)
        r_count <= r_count - LVL_W'(1);
      if (w_drop)
        r_overflow <= 1'b1;
      else if (clear_overflow)
        r_overflow <= 1'b0;
    end
  end

  assign out_if.out_valid = w_valid;
  assign out_if.out_mag   = r_mem_mag[r_rd_ptr];
  assign out_if.out_ang   = r_mem_ang[r_rd_ptr];
  assign out_if.out_id    = r_mem_id[r_rd_ptr];
  assign fifo_level       = r_count;
  assign overflow         = r_overflow;
endmodule

// File: tb/tb_vectoring_postproc.sv
// Directed bench for vectoring_postproc: table-driven streaming vectors plus
// hand-written stall, overflow, full push/pop and asynchronous reset sequences.
module tb_vectoring_postproc;
  localparam int DW = 12;
  localparam int IW = 8;
  localparam int FD = 4;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic signed [DW-1:0] in_mag = '0;
  logic signed [DW-1:0] in_ang = '0;
  logic [IW-1:0]        in_id = '0;
  logic [$clog2(FD):0]  fifo_level;
  logic                 overflow;
  logic                 clear_overflow = 1'b0;

  vectoring_postproc_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  vectoring_postproc #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .INV_GAIN(2487), .PI_Q48(804), .FIFO_DEPTH(FD)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_mag         (in_mag),
    .in_ang         (in_ang),
    .in_id          (in_id),
    .out_if         (bus.master),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int mag;
    int ang;
    int id;
    int emag;
    int eang;
  } vec_t;

  vec_t tbl[9];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int mag, input int ang, input int id);
    in_mag = DW'(mag);
    in_ang = DW'(ang);
    in_id  = IW'(id);
  endtask

  // Stream tbl[first +: n] one per cycle with out_ready high and check order, values and timing.
  task automatic run_table(input int first, input int n, input int max_lvl);
    int exp_i    = first;
    int got      = 0;
    int first_c  = -1;
    int last_c   = -1;
    int lvl_max  = 0;
    int first_nz = -1;
    int last_nz  = -1;
    int n_exp    = 0;
    for (int k = 0; k < n; k++) begin
      if (tbl[first+k].id != 0) begin
        if (first_nz < 0) first_nz = k;
        last_nz = k;
        n_exp++;
      end
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < n + 8; c++) begin
      if (c < n) drive(tbl[first+c].mag, tbl[first+c].ang, tbl[first+c].id);
      else       drive(0, 0, 0);
      tick();
      if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
      if (bus.out_valid) begin
        while (exp_i < first + n && tbl[exp_i].id == 0) exp_i++;
        if (exp_i < first + n) begin
          chk($sformatf("v%0d_mag", exp_i), int'(bus.out_mag), tbl[exp_i].emag);
          chk($sformatf("v%0d_ang", exp_i), int'(bus.out_ang), tbl[exp_i].eang);
          chk($sformatf("v%0d_id", exp_i), int'(bus.out_id), tbl[exp_i].id);
          exp_i++;
        end else begin
          n_checks++;
          n_err++;
          $display("FAIL extra_output: got id %0d expected no output", bus.out_id);
        end
        got++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
    end
    chk($sformatf("grp%0d_count", first), got, n_exp);
    chk($sformatf("grp%0d_latency", first), first_c, first_nz + 2);
    chk($sformatf("grp%0d_spacing", first), last_c - first_c, last_nz - first_nz);
    chk($sformatf("grp%0d_max_level", first), lvl_max, max_lvl);
  endtask

  initial begin
    int k;
    int seen;

    tbl[0] = '{422, 201, 1, 256, 201};
    tbl[1] = '{1890, 900, 1, 1148, 804};
    tbl[2] = '{2047, -900, 2, 1243, -804};
    tbl[3] = '{-5, 804, 3, 0, 804};
    tbl[4] = '{0, -804, 4, 0, -804};
    tbl[5] = '{100, 50, 3, 61, 50};
    tbl[6] = '{0, 0, 0, 0, 0};
    tbl[7] = '{1000, -300, 7, 607, -300};
    tbl[8] = '{0, 0, 0, 0, 0};

    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_mag", int'(bus.out_mag), 0);
    chk("rst_ang", int'(bus.out_ang), 0);
    chk("rst_id", int'(bus.out_id), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_overflow", int'(overflow), 0);
    reset = 1'b1;
    tick();

    run_table(0, 1, 1);
    run_table(1, 4, 1);
    run_table(5, 4, 1);

    // Stall: six pushes into a four-entry FIFO drop ids 5 and 6.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      drive(i * 100, i * 10, i);
      tick();
    end
    drive(0, 0, 0);
    repeat (3) tick();
    chk("stall_level", int'(fifo_level), 4);
    chk("stall_overflow", int'(overflow), 1);
    chk("stall_valid", int'(bus.out_valid), 1);
    chk("stall_id", int'(bus.out_id), 1);
    chk("stall_mag", int'(bus.out_mag), 61);
    chk("stall_ang", int'(bus.out_ang), 10);
    repeat (3) tick();
    chk("hold_valid", int'(bus.out_valid), 1);
    chk("hold_id", int'(bus.out_id), 1);
    chk("hold_mag", int'(bus.out_mag), 61);
    chk("hold_overflow", int'(overflow), 1);

    bus.out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.out_valid) begin
        if (k < 4) chk($sformatf("drain_id%0d", k), int'(bus.out_id), k + 1);
        else begin
          n_checks++;
          n_err++;
          $display("FAIL drain_extra: got id %0d expected no output", bus.out_id);
        end
        k++;
      end
      tick();
    end
    chk("drain_count", k, 4);
    chk("drain_level", int'(fifo_level), 0);
    chk("overflow_sticky", int'(overflow), 1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("overflow_cleared", int'(overflow), 0);

    // Full FIFO: push id 9 on the same edge as a pop.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(i * 100, i * 10, i);
      tick();
    end
    drive(0, 0, 0);
    repeat (3) tick();
    chk("full_level", int'(fifo_level), 4);
    drive(422, 201, 9);
    tick();
    drive(0, 0, 0);
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("pp_level", int'(fifo_level), 4);
    chk("pp_overflow", int'(overflow), 0);
    chk("pp_head", int'(bus.out_id), 2);
    bus.out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.out_valid) begin
        if (k < 4) chk($sformatf("pp_id%0d", k), int'(bus.out_id), (k == 3) ? 9 : k + 2);
        if (k == 3) chk("pp_mag9", int'(bus.out_mag), 256);
        k++;
      end
      tick();
    end
    chk("pp_count", k, 4);
    chk("pp_overflow_end", int'(overflow), 0);

    // Asynchronous reset mid-cycle with entries buffered and in flight.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(i * 100, i * 10, i);
      tick();
    end
    drive(0, 0, 0);
    tick();
    #3;
    reset = 1'b0;
    #1;
    chk("arst_valid", int'(bus.out_valid), 0);
    chk("arst_level", int'(fifo_level), 0);
    chk("arst_id", int'(bus.out_id), 0);
    #2;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("arst_stale", seen, 0);
    chk("arst_level_end", int'(fifo_level), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
